// File: rtl/pkt_prio_sched.sv
// pkt_prio_sched
//   Strict-priority dequeue scheduler. Incoming tagger words are sorted into
//   per-class circular FIFOs (class = prior-1, clamped to NUM_PRIO-1). The
//   oldest word of the highest-priority non-empty class is presented on a
//   registered output stage. Priority-0 (untagged) words are discarded and
//   counted in a saturating drop counter.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   in_valid      tagger word valid
//   in_data       tagger payload
//   in_prior      tagger priority, 0 = untagged
//   in_ready      word accepted when in_valid & in_ready (0 while in reset)
//   out_deque_en  consumer pops the presented word
//   out_valid     output stage holds a word
//   out_data      presented payload
//   out_prior     original in_prior of the presented word
//   drop_cnt      count of discarded prior-0 words, saturating
module pkt_prio_sched #(
  parameter int DWIDTH   = 32,
  parameter int NUM_PRIO = 8,
  parameter int DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  input  logic [5:0]        in_prior,
  output logic              in_ready,
  input  logic              out_deque_en,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  output logic [5:0]        out_prior,
  output logic [15:0]       drop_cnt
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam int CLSW = (NUM_PRIO > 1) ? $clog2(NUM_PRIO) : 1;
  localparam int EW   = DWIDTH + 6;

  logic [EW-1:0]   mem   [NUM_PRIO][DEPTH];
  logic [PW-1:0]   wptr  [NUM_PRIO];
  logic [PW-1:0]   rptr  [NUM_PRIO];
  logic [CNTW-1:0] count [NUM_PRIO];

  logic            prior0;
  logic [CLSW-1:0] cls;
  logic            accept;
  logic            acc_word;
  logic            acc_drop;
  logic            load;
  logic            pop_any;
  logic [CLSW-1:0] pop_cls;
  logic            do_pop;

  // Class selection; cls is meaningless when prior0 is set.
  always_comb begin
    prior0 = (in_prior == 6'd0);
    if (32'(in_prior) >= 32'(NUM_PRIO))
      cls = CLSW'(NUM_PRIO - 1);
    else
      cls = CLSW'(in_prior - 6'd1);
  end

  always_comb begin
    if (!rst)
      in_ready = 1'b0;
    else if (prior0)
      in_ready = 1'b1;
    else
      in_ready = (count[cls] != CNTW'(DEPTH));
  end

  assign accept   = in_valid & in_ready;
  assign acc_word = accept & ~prior0;
  assign acc_drop = accept & prior0;
  assign load     = ~out_valid | out_deque_en;

  // Lowest-index non-empty class wins; scanning downward lets the last
  // assignment be the lowest index. Uses registered counts only, so a word
  // written this cycle is never eligible this cycle.
  always_comb begin
    pop_any = 1'b0;
    pop_cls = '0;
    for (int unsigned i = NUM_PRIO; i > 0; i--) begin
      if (count[i-1] != '0) begin
        pop_any = 1'b1;
        pop_cls = CLSW'(i - 1);
      end
    end
  end

  assign do_pop = load & pop_any;

  // Payload storage carries no reset; pointers and counts define validity.
  always_ff @(posedge clk) begin
    if (acc_word)
      mem[cls][wptr[cls]] <= {in_prior, in_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_PRIO; i++) begin
        wptr[i]  <= '0;
        rptr[i]  <= '0;
        count[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_PRIO; i++) begin
        if (acc_word && (cls == CLSW'(i)))
          wptr[i] <= wptr[i] + PW'(1);
        if (do_pop && (pop_cls == CLSW'(i)))
          rptr[i] <= rptr[i] + PW'(1);
        case ({acc_word && (cls == CLSW'(i)), do_pop && (pop_cls == CLSW'(i))})
          2'b10:   count[i] <= count[i] + CNTW'(1);
          2'b01:   count[i] <= count[i] - CNTW'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_prior <= '0;
    end else if (load) begin
      if (pop_any) begin
        out_valid <= 1'b1;
        {out_prior, out_data} <= mem[pop_cls][rptr[pop_cls]];
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      drop_cnt <= '0;
    else if (acc_drop && (drop_cnt != '1))
      drop_cnt <= drop_cnt + 16'd1;
  end

endmodule

// File: tb/tb_pkt_prio_sched.sv
module tb_pkt_prio_sched;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic [5:0]  in_prior;
  logic        in_ready;
  logic        out_deque_en;
  logic        out_valid;
  logic [31:0] out_data;
  logic [5:0]  out_prior;
  logic [15:0] drop_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  pkt_prio_sched #(.DWIDTH(32), .NUM_PRIO(8), .DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_prior     (in_prior),
    .in_ready     (in_ready),
    .out_deque_en (out_deque_en),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_prior    (out_prior),
    .drop_cnt     (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge; inputs driven afterwards apply to the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [5:0] p);
    in_valid = v;
    in_data  = d;
    in_prior = p;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    out_deque_en = 1'b0;
    drive(1'b1, 32'hDEAD, 6'd3);

    // Reset / idle
    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_prior", out_prior, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    drive(1'b0, 32'h0, 6'd0);
    rst = 1'b1;
    repeat (3) tick();
    check("idle_out_valid", out_valid, 0);

    // Single word latency
    out_deque_en = 1'b1;
    drive(1'b1, 32'hA5, 6'd3);
    check("single_in_ready", in_ready, 1);
    tick();
    drive(1'b0, 32'h0, 6'd0);
    check("single_n_valid", out_valid, 0);
    tick();
    check("single_n1_valid", out_valid, 1);
    check("single_n1_data", out_data, 32'hA5);
    check("single_n1_prior", out_prior, 3);
    tick();
    check("single_n2_valid", out_valid, 0);

    // Priority order
    out_deque_en = 1'b0;
    drive(1'b1, 32'h11, 6'd5); tick();
    drive(1'b1, 32'h22, 6'd2); tick();
    drive(1'b1, 32'h33, 6'd2); tick();
    drive(1'b1, 32'h44, 6'd1); tick();
    drive(1'b0, 32'h0, 6'd0);
    check("prio_first_data", out_data, 32'h11);
    check("prio_first_prior", out_prior, 5);
    out_deque_en = 1'b1;
    tick();
    check("prio_2_data", out_data, 32'h44);
    check("prio_2_prior", out_prior, 1);
    tick();
    check("prio_3_data", out_data, 32'h22);
    tick();
    check("prio_4_data", out_data, 32'h33);
    check("prio_4_valid", out_valid, 1);
    tick();
    check("prio_empty_valid", out_valid, 0);

    // Class full and clamp: prior 20 maps to class 7
    out_deque_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 6'd20);
      check("full_push_ready", in_ready, 1);
      tick();
    end
    drive(1'b0, 32'h0, 6'd20);
    check("full_class7_ready", in_ready, 0);
    drive(1'b0, 32'h0, 6'd1);
    check("full_prio1_ready", in_ready, 1);
    drive(1'b0, 32'h0, 6'd0);
    check("full_prio0_ready", in_ready, 1);
    check("full_out_data", out_data, 32'h100);
    check("full_out_prior", out_prior, 20);
    out_deque_en = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      check("full_drain_data", out_data, 32'h100 + 32'(i));
    end
    tick();
    check("full_drain_empty", out_valid, 0);
    out_deque_en = 1'b0;

    // Drop counter and saturation
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h5000 + 32'(i), 6'd0);
      tick();
    end
    drive(1'b0, 32'h0, 6'd0);
    check("drop_cnt_3", drop_cnt, 3);
    check("drop_out_valid", out_valid, 0);
    drive(1'b1, 32'h0, 6'd0);
    repeat (65532) tick();
    drive(1'b0, 32'h0, 6'd0);
    check("drop_cnt_max", drop_cnt, 16'hFFFF);
    drive(1'b1, 32'h0, 6'd0);
    tick();
    drive(1'b0, 32'h0, 6'd0);
    check("drop_cnt_sat", drop_cnt, 16'hFFFF);

    // Simultaneous push/pop streaming with pointer wrap
    out_deque_en = 1'b1;
    for (int k = 0; k < 22; k++) begin
      if (k < 20) begin
        drive(1'b1, 32'h200 + 32'(k), 6'd4);
        check("stream_in_ready", in_ready, 1);
      end else begin
        drive(1'b0, 32'h0, 6'd0);
      end
      tick();
      if (k >= 1 && k <= 20) begin
        check("stream_valid", out_valid, 1);
        check("stream_data", out_data, 32'h200 + 32'(k - 1));
      end else begin
        check("stream_idle_valid", out_valid, 0);
      end
    end

    // Reset asserted mid-operation drops buffered words asynchronously
    out_deque_en = 1'b0;
    drive(1'b1, 32'h77, 6'd2); tick();
    drive(1'b1, 32'h78, 6'd2); tick();
    drive(1'b0, 32'h0, 6'd0);
    check("midrst_pre_valid", out_valid, 1);
    #2 rst = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_data", out_data, 0);
    check("midrst_drop", drop_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 32'h99, 6'd6);
    check("midrst_ready", in_ready, 1);
    tick();
    drive(1'b0, 32'h0, 6'd0);
    tick();
    check("midrst_new_valid", out_valid, 1);
    check("midrst_new_data", out_data, 32'h99);
    out_deque_en = 1'b1;
    tick();
    check("midrst_no_stale", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
